line_rasterizer: RTL and testbench
==================================

Name: line_rasterizer

Overview:
- Pixel producer for the VGA framebuffer's pixel-write port (x, y, z, pixel_color, pixel_write).
- Accepts one line command per valid/ready handshake.
- Walks the line with integer Bresenham and emits one pixel write per clk50 cycle, with constant z and color for the whole line.
- Suppresses writes for pixels outside the 640x480 active area; stepping continues through clipped pixels.

Parameters:
- XRES, 640, horizontal resolution; pixels with x >= XRES are clipped.
- YRES, 480, vertical resolution; pixels with y >= YRES are clipped.

Ports:
- clk50  input  1  system clock, 50 MHz
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present on cmd_* inputs
- cmd_ready  output  1  block idle, command accepted when cmd_valid is also high
- cmd_x0  input  11  start x, unsigned
- cmd_y0  input  11  start y, unsigned
- cmd_x1  input  11  end x, unsigned
- cmd_y1  input  11  end y, unsigned
- cmd_z  input  16  depth applied to every pixel of the line
- cmd_color  input  2  color index applied to every pixel of the line
- x  output  11  current pixel x
- y  output  11  current pixel y
- z  output  16  latched cmd_z
- pixel_color  output  2  latched cmd_color
- pixel_write  output  1  pixel write strobe, one pixel per cycle
- done  output  1  one-cycle pulse after the last pixel of a line

Behaviour:
- Reset (asynchronous): state IDLE; x, y, z, pixel_color, all internal registers = 0; pixel_write = 0; done = 0; cmd_ready = 1.
- Reset asserted mid-line aborts the line immediately; no further writes and no done pulse.
- States:
  - IDLE: cmd_ready = 1. On cmd_valid at a clock edge, latch all cmd_* fields; go to SETUP.
  - SETUP: one cycle.
    - dx = |x1-x0|; dy = -|y1-y0|.
    - sx = +1 if x0 < x1, else -1; sy = +1 if y0 < y1, else -1.
    - err = dx + dy.
    - x = x0, y = y0. Go to DRAW.
  - DRAW: each cycle presents the current (x, y).
    - If x == x1 and y == y1: go to DONE.
    - Otherwise, with e2 = 2*err from the pre-update err:
      - if e2 >= dy: x += sx, and dy is added to err;
      - if e2 <= dx: y += sy, and dx is added to err;
      - both conditions may fire in the same cycle, and both contributions are summed into err in that cycle.
  - DONE: done = 1 for exactly this one cycle, pixel_write = 0; go to IDLE.
- cmd_ready is high only in IDLE. Commands are not queued; cmd_valid outside IDLE is ignored.
- pixel_write = (state == DRAW) && (x < XRES) && (y < YRES). It is derived from registered state, so the outputs x, y, z and pixel_color are stable for the whole cycle pixel_write is high.
- Latency:
  - Command accepted at edge k: SETUP during cycle k..k+1.
  - First pixel presented after edge k+1.
  - Pixel count N = max(dx, |dy|) + 1, one per consecutive cycle with no gaps.
  - done is high in the cycle after the last DRAW cycle.
  - The next command can be accepted at the edge ending the cycle after done (IDLE cycle).
- Arithmetic:
  - dx and |dy| are 11-bit unsigned.
  - err and e2 are 13-bit signed, which is sufficient for 11-bit coordinates.
  - x and y step modulo 2^11. Stepping never leaves the [x0, x1] / [y0, y1] ranges, so no wrap occurs.
- Boundary cases:
  - Degenerate line (x0 == x1, y0 == y1): exactly one pixel.
  - Horizontal, vertical, 45-degree, steep, and reversed-direction lines are all supported.
  - Fully off-screen line: runs its full cycle count with pixel_write = 0 throughout, then pulses done.

Test Plan:
1. Horizontal line: cmd (0,0)->(3,0), z=5, color=1 -> pixel_write on 4 consecutive cycles at x = 0, 1, 2, 3, y = 0, z = 5, color = 1; done in the following cycle; cmd_ready = 0 from acceptance until the IDLE cycle after done.
2. Steep line: cmd (0,0)->(2,4) -> writes at (0,0), (1,1), (1,2), (2,3), (2,4) on consecutive cycles; 5 writes total.
3. Reversed and degenerate lines:
   - cmd (3,2)->(0,2) -> x = 3, 2, 1, 0 at y = 2.
   - cmd (5,5)->(5,5) -> exactly one write at (5,5), then done.
4. Clipping: cmd (638,479)->(641,479) -> 4 DRAW cycles; pixel_write high only for x = 638 and 639; done pulses once; no writes appear at x = 640 or 641.
5. Handshake:
   - cmd_valid held high continuously with two different commands back-to-back -> the second is accepted only in the IDLE cycle after the first line's done.
   - Changing cmd_* fields during DRAW has no effect on the line in progress.
6. Reset mid-line: assert reset during the 3rd DRAW cycle of (0,0)->(9,0) -> pixel_write = 0, x = y = 0, and cmd_ready = 1 immediately (asynchronous); no done pulse; a subsequent command draws correctly.

Source files
------------

// File: rtl/line_rasterizer.sv
// Bresenham line walker feeding the framebuffer pixel-write port.
// One command per handshake, one pixel per clk50 cycle, clipped to XRES x YRES.
module line_rasterizer #(
    parameter int XRES = 640,
    parameter int YRES = 480
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [10:0] cmd_x0,
    input  logic [10:0] cmd_y0,
    input  logic [10:0] cmd_x1,
    input  logic [10:0] cmd_y1,
    input  logic [15:0] cmd_z,
    input  logic [1:0]  cmd_color,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic [15:0] z,
    output logic [1:0]  pixel_color,
    output logic        pixel_write,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

    localparam logic [10:0] XLIM = 11'(XRES);
    localparam logic [10:0] YLIM = 11'(YRES);

    state_t             state;
    logic [10:0]        x0_q, y0_q, x1_q, y1_q;
    logic [10:0]        dx;
    logic signed [12:0] dy;
    logic signed [12:0] err;
    logic               sx_neg, sy_neg;

    logic [10:0]        abs_dx, abs_dy;
    logic signed [12:0] dx_s, e2, err_next;
    logic               step_x, step_y;

    assign abs_dx = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
    assign abs_dy = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
    assign dx_s   = $signed({2'b00, dx});
    assign e2     = err <<< 1;
    assign step_x = (e2 >= dy);
    assign step_y = (e2 <= dx_s);

    // Both axis contributions land in err in the same cycle when both fire.
    always_comb begin
        err_next = err;
        if (step_x) err_next = err_next + dy;
        if (step_y) err_next = err_next + dx_s;
    end

    assign pixel_write = (state == DRAW) && (x < XLIM) && (y < YLIM);

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            done        <= 1'b0;
            x0_q        <= '0;
            y0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            z           <= '0;
            pixel_color <= '0;
            dx          <= '0;
            dy          <= '0;
            err         <= '0;
            sx_neg      <= 1'b0;
            sy_neg      <= 1'b0;
            x           <= '0;
            y           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        x0_q        <= cmd_x0;
                        y0_q        <= cmd_y0;
                        x1_q        <= cmd_x1;
                        y1_q        <= cmd_y1;
                        z           <= cmd_z;
                        pixel_color <= cmd_color;
                        cmd_ready   <= 1'b0;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    dx     <= abs_dx;
                    dy     <= -$signed({2'b00, abs_dy});
                    err    <= $signed({2'b00, abs_dx}) - $signed({2'b00, abs_dy});
                    sx_neg <= !(x0_q < x1_q);
                    sy_neg <= !(y0_q < y1_q);
                    x      <= x0_q;
                    y      <= y0_q;
                    state  <= DRAW;
                end
                DRAW: begin
                    if (x == x1_q && y == y1_q) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        if (step_x) x <= sx_neg ? (x - 11'd1) : (x + 11'd1);
                        if (step_y) y <= sy_neg ? (y - 11'd1) : (y + 11'd1);
                        err <= err_next;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_rasterizer.sv
// Randomized and directed stimulus against an integer Bresenham point-list model.
module tb_line_rasterizer;

    logic        clk50;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [10:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
    logic [15:0] cmd_z;
    logic [1:0]  cmd_color;
    logic [10:0] x, y;
    logic [15:0] z;
    logic [1:0]  pixel_color;
    logic        pixel_write;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    line_rasterizer #(.XRES(640), .YRES(480)) dut (
        .clk50       (clk50),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x0      (cmd_x0),
        .cmd_y0      (cmd_y0),
        .cmd_x1      (cmd_x1),
        .cmd_y1      (cmd_y1),
        .cmd_z       (cmd_z),
        .cmd_color   (cmd_color),
        .x           (x),
        .y           (y),
        .z           (z),
        .pixel_color (pixel_color),
        .pixel_write (pixel_write),
        .done        (done)
    );

    initial clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Caller is at a negedge; returns at the negedge of the IDLE cycle after done.
    task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int az, input int ac, input bit hold,
                            input int nx0, input int ny0, input int nx1, input int ny1,
                            input int nz, input int nc);
        int qx[$];
        int qy[$];
        int px, py, ddx, ddy, sx, sy, e, e2, t;
        ddx = iabs(ax1 - ax0);
        ddy = -iabs(ay1 - ay0);
        sx  = (ax0 < ax1) ? 1 : -1;
        sy  = (ay0 < ay1) ? 1 : -1;
        e   = ddx + ddy;
        px  = ax0;
        py  = ay0;
        forever begin
            qx.push_back(px);
            qy.push_back(py);
            if (px == ax1 && py == ay1) break;
            e2 = 2 * e;
            if (e2 >= ddy) begin e += ddy; px += sx; end
            if (e2 <= ddx) begin e += ddx; py += sy; end
        end

        cmd_x0 = 11'(ax0); cmd_y0 = 11'(ay0);
        cmd_x1 = 11'(ax1); cmd_y1 = 11'(ay1);
        cmd_z = 16'(az); cmd_color = 2'(ac);
        cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clk50);
            t++;
        end
        check("ready_wait", cmd_ready, 1);
        @(negedge clk50);
        check("ready_setup", cmd_ready, 0);
        check("pw_setup", pixel_write, 0);
        if (hold) begin
            cmd_x0 = 11'(nx0); cmd_y0 = 11'(ny0);
            cmd_x1 = 11'(nx1); cmd_y1 = 11'(ny1);
            cmd_z = 16'(nz); cmd_color = 2'(nc);
        end else begin
            cmd_valid = 1'b0;
            cmd_x0 = 11'($urandom); cmd_y0 = 11'($urandom);
            cmd_x1 = 11'($urandom); cmd_y1 = 11'($urandom);
            cmd_z = 16'($urandom); cmd_color = 2'($urandom);
        end
        for (int i = 0; i < qx.size(); i++) begin
            @(negedge clk50);
            check("x", x, qx[i]);
            check("y", y, qy[i]);
            check("z", z, az);
            check("color", pixel_color, ac);
            check("pw", pixel_write, (qx[i] < 640 && qy[i] < 480) ? 1 : 0);
            check("done_draw", done, 0);
            check("ready_draw", cmd_ready, 0);
        end
        @(negedge clk50);
        check("done_pulse", done, 1);
        check("pw_done", pixel_write, 0);
        check("ready_done", cmd_ready, 0);
        @(negedge clk50);
        check("done_clear", done, 0);
        check("ready_idle", cmd_ready, 1);
    endtask

    task automatic line(input int ax0, input int ay0, input int ax1, input int ay1,
                        input int az, input int ac);
        run_line(ax0, ay0, ax1, ay1, az, ac, 1'b0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic int near(input int base);
        int v;
        v = base + int'($urandom_range(0, 80)) - 40;
        if (v < 0) v = 0;
        if (v > 2047) v = 2047;
        return v;
    endfunction

    initial begin
        int t;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0;
        cmd_z = '0; cmd_color = '0;
        repeat (2) @(negedge clk50);
        check("rst_ready", cmd_ready, 1);
        check("rst_pw", pixel_write, 0);
        check("rst_done", done, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_z", z, 0);
        check("rst_color", pixel_color, 0);
        reset = 1'b0;
        @(negedge clk50);

        line(0, 0, 3, 0, 5, 1);
        line(0, 0, 2, 4, 9, 2);
        line(3, 2, 0, 2, 7, 3);
        line(5, 5, 5, 5, 1, 0);
        line(638, 479, 641, 479, 3, 2);
        run_line(10, 10, 14, 12, 100, 1, 1'b1, 20, 5, 17, 9, 200, 2);
        line(20, 5, 17, 9, 200, 2);
        line(1000, 600, 1010, 620, 4, 1);
        line(2047, 2047, 2030, 2040, 6, 3);

        // Reset during the third DRAW cycle of a horizontal line.
        cmd_x0 = 11'd0; cmd_y0 = 11'd0; cmd_x1 = 11'd9; cmd_y1 = 11'd0;
        cmd_z = 16'd11; cmd_color = 2'd1;
        cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clk50);
            t++;
        end
        @(negedge clk50);
        cmd_valid = 1'b0;
        @(negedge clk50);
        @(negedge clk50);
        check("pre_rst_x", x, 1);
        @(posedge clk50);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_pw", pixel_write, 0);
        check("mid_rst_x", x, 0);
        check("mid_rst_y", y, 0);
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_done", done, 0);
        @(negedge clk50);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk50);
            check("post_rst_done", done, 0);
            check("post_rst_pw", pixel_write, 0);
        end
        line(0, 0, 9, 0, 12, 2);

        for (int k = 0; k < 25; k++) begin
            int mode, a0, b0, a1, b1;
            mode = int'($urandom_range(0, 2));
            if (mode == 0) begin
                a0 = int'($urandom_range(0, 63)); b0 = int'($urandom_range(0, 63));
                a1 = int'($urandom_range(0, 63)); b1 = int'($urandom_range(0, 63));
            end else if (mode == 1) begin
                a0 = int'($urandom_range(600, 700)); b0 = int'($urandom_range(440, 520));
                a1 = near(a0); b1 = near(b0);
            end else begin
                a0 = int'($urandom_range(0, 2047)); b0 = int'($urandom_range(0, 2047));
                a1 = near(a0); b1 = near(b0);
            end
            line(a0, b0, a1, b1, int'($urandom_range(0, 65535)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
